// File: rtl/shift_arbiter_seq.sv
// shift_arbiter_seq: iterative shift engine shared by two requesters.
// Round-robin arbitration in IDLE, one power-of-two shift stage per clock in
// SHIFT, and a held valid/ready response tagged with the requester id in DONE.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   reqN_valid/reqN_ready request handshake for requester N (N = 0, 1)
//   reqN_a/amt/op         operand, shift amount, op (00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_data      requester that issued the result, shifted result
//   busy                  high whenever the engine is not idle
module shift_arbiter_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [AMT_W-1:0] LastStage = AMT_W'(AMT_W - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_last_grant;
  logic [AMT_W-1:0] r_stage;
  logic [AMT_W-1:0] r_amt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_work;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic             w_last_stage;
  logic [AMT_W-1:0] w_dist;
  logic [AMT_W:0]   w_rot_l;
  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_step;

  // Grant: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_idle     = (r_state == StIdle);
  assign w_accept   = w_idle & (req0_valid | req1_valid);
  assign req0_ready = w_idle & req0_valid & ~w_grant;
  assign req1_ready = w_idle & req1_valid & w_grant;
  assign busy       = ~w_idle;

  // Stage k shifts by 2^k; the one-hot 1<<k is both the distance and the amt bit mask.
  assign w_last_stage = (r_stage == LastStage);
  assign w_dist       = AMT_W'(1) << r_stage;
  assign w_rot_l      = (AMT_W + 1)'(WIDTH) - {1'b0, w_dist};
  assign w_sll        = r_work << w_dist;
  assign w_srl        = r_work >> w_dist;
  // Arithmetic shifts keep the MSB, so it stays the original operand sign.
  assign w_sra        = $signed(r_work) >>> w_dist;
  assign w_ror        = (r_work >> w_dist) | (r_work << w_rot_l);

  always_comb begin
    w_shifted = w_sll;
    case (r_op)
      2'b00:   w_shifted = w_sll;
      2'b01:   w_shifted = w_srl;
      2'b10:   w_shifted = w_sra;
      default: w_shifted = w_ror;
    endcase
  end

  assign w_step = (|(r_amt & w_dist)) ? w_shifted : r_work;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StShift;
      StShift: if (w_last_stage) w_state_next = StDone;
      StDone:  if (rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_stage      <= '0;
      r_amt        <= '0;
      r_op         <= '0;
      r_work       <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_work       <= w_grant ? req1_a : req0_a;
            r_amt        <= w_grant ? req1_amt : req0_amt;
            r_op         <= w_grant ? req1_op : req0_op;
            rsp_id       <= w_grant;
            r_last_grant <= w_grant;
            r_stage      <= '0;
          end
        end
        StShift: begin
          r_work  <= w_step;
          r_stage <= r_stage + AMT_W'(1);
          if (w_last_stage) begin
            rsp_data  <= w_step;
            rsp_valid <= 1'b1;
          end
        end
        StDone: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
